apb_master_initiator: RTL and testbench
=======================================

Name: apb_master_initiator

Overview:
APB initiator that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers. It targets the team's APB slave register file, which holds the SENT transmitter configuration and FIFOs. It replaces bench-driven APB stimulus with synthesizable RTL, so on-chip controllers can program the SENT block. A PREADY timeout guarantees the initiator never hangs on an unresponsive slave.

Parameters:
ADDRESSWIDTH, 4, width of PADDR and cmd_addr
DATAWIDTH, 8, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
PCLK  input  1  single clock, rising edge
PRESETn  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on an edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDRESSWIDTH  target register address
cmd_wdata  input  DATAWIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high
rsp_rdata  output  DATAWIDTH  read data; 0 for writes and for timeouts
rsp_timeout  output  1  transfer ended by timeout rather than PREADY
busy  output  1  high in any state other than IDLE
PADDR  output  ADDRESSWIDTH  APB address
PWDATA  output  DATAWIDTH  APB write data
PWRITE  output  1  APB direction
PSELx  output  1  APB select
PENABLE  output  1  APB enable
PRDATA  input  DATAWIDTH  APB read data
PREADY  input  1  APB ready

Behaviour:
- Clocking: one clock, PCLK. Reset is asynchronous and active-low on PRESETn.
- All outputs are registered, except cmd_ready and busy, which decode directly from state.
- Reset values: every output is 0 and the state is IDLE. A reset asserted mid-transfer forces all outputs to 0 immediately and drops the transfer; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0.
  - Clear the timeout counter, then go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - PREADY=1: capture PRDATA into rsp_rdata if PWRITE=0, else load 0. Set rsp_timeout=0 and go to RESP.
  - PREADY=0 and TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1: set rsp_rdata=0, rsp_timeout=1 and go to RESP.
  - Otherwise increment the counter.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- RESP:
  - PSELx=0, PENABLE=0, rsp_valid=1.
  - rsp_rdata and rsp_timeout stay stable until rsp_ready is high, then go to IDLE.
- Bus stability:
  - PADDR, PWDATA and PWRITE do not change from SETUP through the end of ACCESS.
  - After a transfer they hold their last values; they are not zeroed.
- Latency: with the command accepted at edge n and PREADY=1 on the first ACCESS cycle:
  - SETUP runs in cycle n+1.
  - ACCESS runs in cycle n+2.
  - rsp_valid is high in cycle n+3.
  - The minimum is 4 cycles per transfer, with no overlap between transfers.
- cmd_valid arriving outside IDLE is ignored (cmd_ready=0); the source must hold it.
- PREADY and PRDATA are ignored outside ACCESS.

Decomposition:
- Shared package (apb_pkg): state enum (IDLE, SETUP, ACCESS, RESP) and APB address constants for the register file (CTRL=2, TX_FIFO=4, DATA_FIFO=6).
- One natural sub-module: apb_timeout_counter. It takes clear and enable inputs, has a saturating count, and outputs an expired flag.

Test Plan:
- Write addr 2, data 0xF4, PREADY tied 1 → PSELx high 2 cycles, PENABLE high 1 cycle, rsp_valid at n+3, rsp_timeout=0, rsp_rdata=0.
- Read addr 6, PREADY low for 3 ACCESS cycles then high with PRDATA=0xA5 → ACCESS lasts 4 cycles, rsp_rdata=0xA5, PADDR stays 6 throughout.
- PREADY held 0 with TIMEOUT_CYCLES=16 → exactly 16 ACCESS cycles, then PSELx/PENABLE drop, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held 0 for 5 cycles after rsp_valid → rsp fields stable, cmd_ready=0, busy=1; the response is consumed on the 6th cycle and cmd_ready=1 follows.
- 15 back-to-back writes to addr 6 with data 0x01..0x0F, rsp_ready=1 → each transfer 4 cycles, PWDATA sequence 0x01..0x0F in order, no dropped command.
- PRESETn pulsed low during ACCESS → PSELx, PENABLE, rsp_valid and busy are 0 immediately; after release a new write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding and the
// register-file addresses of the SENT transmitter block.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int unsigned APB_ADDR_CTRL      = 2;
  localparam int unsigned APB_ADDR_TX_FIFO   = 4;
  localparam int unsigned APB_ADDR_DATA_FIFO = 6;

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait counter for the ACCESS phase; expired flags the last
// permitted wait cycle. LIMIT=0 disables expiry.
module apb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] COUNT_MAX = '1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != COUNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_initiator.sv
// Command-stream to APB bridge: one SETUP/ACCESS transfer per accepted
// command, result returned on a valid/ready response channel.
module apb_master_initiator
  import apb_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH   = 4,
  parameter int unsigned DATAWIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);

  apb_state_t state_reg, state_next;

  logic [ADDRESSWIDTH-1:0] paddr_reg, paddr_next;
  logic [DATAWIDTH-1:0]    pwdata_reg, pwdata_next;
  logic                    pwrite_reg, pwrite_next;
  logic                    psel_reg, psel_next;
  logic                    penable_reg, penable_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [DATAWIDTH-1:0]    rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_timeout_reg, rsp_timeout_next;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pwrite_reg      <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      pwrite_reg      <= pwrite_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    pwrite_next      = pwrite_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_timeout_next = rsp_timeout_reg;
    cnt_clear        = 1'b0;
    cnt_enable       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwdata_next = cmd_wdata;
          pwrite_next = cmd_write;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        cnt_clear  = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over expiry on the last permitted wait cycle
        if (PREADY) begin
          rsp_rdata_next   = pwrite_reg ? '0 : PRDATA;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (cnt_expired) begin
          rsp_rdata_next   = '0;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Bus strobes are registered, so they follow the state being entered
    psel_next      = (state_next == SETUP) || (state_next == ACCESS);
    penable_next   = (state_next == ACCESS);
    rsp_valid_next = (state_next == RESP);
  end

  assign cmd_ready   = PRESETn && (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign PADDR       = paddr_reg;
  assign PWDATA      = pwdata_reg;
  assign PWRITE      = pwrite_reg;
  assign PSELx       = psel_reg;
  assign PENABLE     = penable_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_initiator.sv
// Self-checking bench for apb_master_initiator: directed table, corner
// sequences and randomized transfers against a transfer-level model.
module tb_apb_master_initiator;
  import apb_pkg::*;

  localparam int TO = 16;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout, busy;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic       PWRITE, PSELx, PENABLE;
  logic [7:0] PRDATA;
  logic       PREADY;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int accept_q[$];
  logic [7:0] pwdata_log[$];

  apb_master_initiator #(
    .ADDRESSWIDTH(4), .DATAWIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    bit         w;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         rd;      // ACCESS cycles with PREADY low before it goes high
    logic [7:0] prdata;
    int         rspd;    // cycles rsp_ready is held low
    logic [7:0] er;
    bit         et;
    int         ea;      // expected ACCESS cycles
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    bit         timeout;
    int         access;
  } exp_t;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Transfer-level model: the slave answers after rd wait cycles unless the
  // wait budget of TO ACCESS cycles runs out first.
  function automatic exp_t model(bit w, logic [7:0] pr, int rd);
    exp_t e;
    e.timeout = (rd >= TO);
    e.access  = e.timeout ? TO : rd + 1;
    e.rdata   = (w || e.timeout) ? 8'h00 : pr;
    return e;
  endfunction

  task automatic do_xfer(input string tag, input bit w, input logic [3:0] a,
                         input logic [7:0] d, input int rd, input logic [7:0] pr,
                         input int rspd, input logic [7:0] er, input bit et,
                         input int ea);
    int acc;
    int t_acc;
    int stable_err;
    int hold_err;
    chk({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK); #1;
    t_acc = cyc;
    accept_q.push_back(t_acc);
    cmd_valid = 1'b0; cmd_wdata = 8'($urandom); cmd_addr = 4'($urandom);
    cmd_write = 1'($urandom);
    chk({tag, "_setup_psel"}, {PSELx, PENABLE}, 2'b10);
    chk({tag, "_setup_bus"}, {PWRITE, PADDR, PWDATA}, {w, a, d});
    pwdata_log.push_back(PWDATA);
    PREADY = 1'($urandom); PRDATA = 8'($urandom);
    @(posedge PCLK); #1;
    acc = 0; stable_err = 0;
    while (PENABLE === 1'b1 && acc < 200) begin
      PREADY = (acc == rd);
      PRDATA = (acc == rd) ? pr : 8'($urandom);
      if (PSELx !== 1'b1 || PADDR !== a || PWDATA !== d || PWRITE !== w)
        stable_err++;
      acc++;
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0;
    chk({tag, "_access_cycles"}, acc, ea);
    chk({tag, "_bus_stable"}, stable_err, 0);
    chk({tag, "_rsp_latency"}, cyc - t_acc, ea + 1);
    chk({tag, "_resp_strobes"}, {rsp_valid, PSELx, PENABLE, busy}, 4'b1001);
    chk({tag, "_rsp_rdata"}, rsp_rdata, er);
    chk({tag, "_rsp_timeout"}, rsp_timeout, et);
    hold_err = 0;
    for (int k = 0; k < rspd; k++) begin
      PREADY = 1'($urandom); PRDATA = 8'($urandom);
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_timeout !== et ||
          cmd_ready !== 1'b0 || busy !== 1'b1)
        hold_err++;
    end
    if (rspd > 0) chk({tag, "_rsp_hold"}, hold_err, 0);
    PREADY = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done_idle"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    chk({tag, "_paddr_held"}, PADDR, a);
    $display("xfer %s w=%0d a=%0h d=%0h rd=%0d rsp=%0d -> rdata=%0h to=%0d acc=%0d",
             tag, w, a, d, rd, rspd, er, et, acc);
  endtask

  vec_t vecs[7];
  exp_t m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0;

    vecs[0] = '{1'b1, 4'(APB_ADDR_CTRL), 8'hF4, 0, 8'h00, 0, 8'h00, 1'b0, 1};
    vecs[1] = '{1'b0, 4'(APB_ADDR_DATA_FIFO), 8'h00, 3, 8'hA5, 0, 8'hA5, 1'b0, 4};
    vecs[2] = '{1'b0, 4'(APB_ADDR_TX_FIFO), 8'h00, 100, 8'h77, 0, 8'h00, 1'b1, 16};
    vecs[3] = '{1'b1, 4'(APB_ADDR_CTRL), 8'h3C, 0, 8'h00, 5, 8'h00, 1'b0, 1};
    vecs[4] = '{1'b0, 4'(APB_ADDR_DATA_FIFO), 8'h11, 15, 8'h5A, 1, 8'h5A, 1'b0, 16};
    vecs[5] = '{1'b0, 4'(APB_ADDR_DATA_FIFO), 8'h22, 16, 8'hC3, 0, 8'h00, 1'b1, 16};
    vecs[6] = '{1'b1, 4'hF, 8'hFF, 2, 8'h99, 2, 8'h00, 1'b0, 3};

    #1;
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
                          PADDR, PWDATA, PWRITE, PSELx, PENABLE}, '0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 7; i++)
      do_xfer($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata,
              vecs[i].rd, vecs[i].prdata, vecs[i].rspd, vecs[i].er, vecs[i].et,
              vecs[i].ea);

    // back-to-back writes with zero-wait slave
    accept_q.delete(); pwdata_log.delete();
    for (int i = 1; i <= 15; i++)
      do_xfer($sformatf("b2b%0d", i), 1'b1, 4'(APB_ADDR_DATA_FIFO), 8'(i),
              0, 8'h00, 0, 8'h00, 1'b0, 1);
    for (int i = 1; i < 15; i++)
      chk($sformatf("b2b_period%0d", i), accept_q[i] - accept_q[i-1], 4);
    for (int i = 0; i < 15; i++)
      chk($sformatf("b2b_pwdata%0d", i), pwdata_log[i], 8'(i + 1));

    // reset asserted in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'(APB_ADDR_DATA_FIFO);
    @(posedge PCLK); #1; cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("pre_reset_access", {PSELx, PENABLE, busy}, 3'b111);
    PRESETn = 1'b0; #1;
    chk("mid_reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
                              PADDR, PWDATA, PWRITE, PSELx, PENABLE}, '0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_reset_no_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
    do_xfer("after_reset", 1'b1, 4'(APB_ADDR_CTRL), 8'h5E, 1, 8'h00, 0,
            8'h00, 1'b0, 2);

    // randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      bit         w;
      logic [3:0] a;
      logic [7:0] d, pr;
      int         rd, rspd;
      w = 1'($urandom); a = 4'($urandom); d = 8'($urandom); pr = 8'($urandom);
      rd = $urandom_range(0, 20); rspd = $urandom_range(0, 3);
      m = model(w, pr, rd);
      do_xfer($sformatf("rnd%0d", i), w, a, d, rd, pr, rspd, m.rdata,
              m.timeout, m.access);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
